mem_port_arb: RTL and testbench

MEM_PORT_ARB -- requirements
Module: mem_port_arb

---
 rtl/mem_port_arb.sv | 234 +++++++++++++++++++++++
 tb/tb_mem_port_arb.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arb.sv
// mem_port_arb: two-requester arbiter in front of a single-port register file.
// Round-robin arbitration with optional ownership locking (up to MAX_LOCK
// consecutive grants), a registered memory-side bus, and a 2-stage requester
// tag pipeline that routes read data back to the issuing port.
// Optional build: define MEM_ARB_FIXED_PRIO_EN for fixed priority (a beats b).
module mem_port_arb #(
  parameter int AW       = 4,
  parameter int DW       = 8,
  parameter int MAX_LOCK = 4
) (
  input  logic          clk,
  input  logic          rst,
  // requester a
  input  logic          req_a,
  input  logic          we_a,
  input  logic          lock_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] wdata_a,
  output logic          gnt_a,
  output logic          rvalid_a,
  output logic [DW-1:0] rdata_a,
  // requester b
  input  logic          req_b,
  input  logic          we_b,
  input  logic          lock_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_b,
  output logic          gnt_b,
  output logic          rvalid_b,
  output logic [DW-1:0] rdata_b,
  // memory side
  output logic          mem_ren,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  // Requester tag travelling alongside a read until its data returns.
  typedef struct packed {
    logic vld;
    logic is_b;
  } tag_t;

  localparam int            CW       = (MAX_LOCK < 2) ? 1 : $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] LOCK_MAX = CW'(MAX_LOCK);
  // With MAX_LOCK <= 1 the entry grant already exhausts the budget, so a
  // lock never produces an owned state.
  localparam bit            LOCK_OK  = (MAX_LOCK > 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_lock_cnt;
  logic [CW-1:0] w_lock_cnt_nxt;
  logic [CW-1:0] w_lock_cnt_inc;
  // Last winner: 1 = b won last, so a is favoured next.
  logic          r_last_b;
  logic          w_favour_a;

  logic          w_gnt_a;
  logic          w_gnt_b;
  logic          w_acc;
  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;

  logic          r_mem_ren;
  logic          r_mem_wen;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;

  tag_t          r_tag1;
  tag_t          r_tag2;
  logic          r_rvalid_a;
  logic          r_rvalid_b;
  logic [DW-1:0] r_rdata_a;
  logic [DW-1:0] r_rdata_b;

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign w_favour_a = 1'b1;
`else
  assign w_favour_a = r_last_b;
`endif

  // Grant decode: owner-only while locked, pointer/priority on contention.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_gnt_a = 1'b0;
    w_gnt_b = 1'b0;
    if (!rst) begin
      case (r_state)
        IDLE: begin
          if (req_a && req_b) begin
            w_gnt_a = w_favour_a;
            w_gnt_b = !w_favour_a;
          end else begin
            w_gnt_a = req_a;
            w_gnt_b = req_b;
          end
        end
        OWN_A:   w_gnt_a = req_a;
        OWN_B:   w_gnt_b = req_b;
        default: ;
      endcase
    end
  end

  assign gnt_a = w_gnt_a;
  assign gnt_b = w_gnt_b;

  // Accepted-request mux toward the memory bus.
  assign w_acc   = w_gnt_a | w_gnt_b;
  assign w_we    = w_gnt_b ? we_b    : we_a;
  assign w_addr  = w_gnt_b ? addr_b  : addr_a;
  assign w_wdata = w_gnt_b ? wdata_b : wdata_a;

  assign w_lock_cnt_inc = r_lock_cnt + CW'(1);

  // Lock FSM next state; the counter includes the grant that entered OWN_x.
  always_comb begin
    w_state_nxt    = r_state;
    w_lock_cnt_nxt = r_lock_cnt;
    case (r_state)
      IDLE: begin
        w_lock_cnt_nxt = '0;
        if (LOCK_OK && w_gnt_a && lock_a) begin
          w_state_nxt    = OWN_A;
          w_lock_cnt_nxt = CW'(1);
        end else if (LOCK_OK && w_gnt_b && lock_b) begin
          w_state_nxt    = OWN_B;
          w_lock_cnt_nxt = CW'(1);
        end
      end
      OWN_A: begin
        if (!req_a || !lock_a || (w_lock_cnt_inc == LOCK_MAX)) begin
          w_state_nxt    = IDLE;
          w_lock_cnt_nxt = '0;
        end else begin
          w_lock_cnt_nxt = w_lock_cnt_inc;
        end
      end
      OWN_B: begin
        if (!req_b || !lock_b || (w_lock_cnt_inc == LOCK_MAX)) begin
          w_state_nxt    = IDLE;
          w_lock_cnt_nxt = '0;
        end else begin
          w_lock_cnt_nxt = w_lock_cnt_inc;
        end
      end
      default: begin
        w_state_nxt    = IDLE;
        w_lock_cnt_nxt = '0;
      end
    endcase
  end

  // FSM state, lock counter and round-robin pointer.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      r_state    <= IDLE;
      r_lock_cnt <= '0;
      r_last_b   <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
      if (w_acc) r_last_b <= w_gnt_b;
    end
  end

  // Memory bus register: strobes only after an acceptance, address/data hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_ren   <= 1'b0;
      r_mem_wen   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_acc) begin
      r_mem_ren   <= !w_we;
      r_mem_wen   <= w_we;
      r_mem_addr  <= w_addr;
      r_mem_wdata <= w_wdata;
    end else begin
      r_mem_ren   <= 1'b0;
      r_mem_wen   <= 1'b0;
    end
  end

  assign mem_ren   = r_mem_ren;
  assign mem_wen   = r_mem_wen;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  // Read tag pipeline: stage 1 aligns with mem_ren, stage 2 with mem_rdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag1 <= '0;
      r_tag2 <= '0;
    end else begin
      r_tag1.vld  <= w_acc && !w_we;
      r_tag1.is_b <= w_gnt_b;
      r_tag2      <= r_tag1;
    end
  end

  // Read return: capture memory data into the tagged port with a 1-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rvalid_a <= 1'b0;
      r_rvalid_b <= 1'b0;
      r_rdata_a  <= '0;
      r_rdata_b  <= '0;
    end else begin
      r_rvalid_a <= r_tag2.vld && !r_tag2.is_b;
      r_rvalid_b <= r_tag2.vld &&  r_tag2.is_b;
      if (r_tag2.vld && !r_tag2.is_b) r_rdata_a <= mem_rdata;
      if (r_tag2.vld &&  r_tag2.is_b) r_rdata_b <= mem_rdata;
    end
  end

  assign rvalid_a = r_rvalid_a;
  assign rvalid_b = r_rvalid_b;
  assign rdata_a  = r_rdata_a;
  assign rdata_b  = r_rdata_b;

endmodule

// File: tb/tb_mem_port_arb.sv
// tb_mem_port_arb: directed bench for mem_port_arb with a behavioural
// 16 x 8 register file (1-cycle read latency) on the memory side.
module tb_mem_port_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_a, we_a, lock_a;
  logic [3:0] addr_a;
  logic [7:0] wdata_a;
  logic       gnt_a, rvalid_a;
  logic [7:0] rdata_a;
  logic       req_b, we_b, lock_b;
  logic [3:0] addr_b;
  logic [7:0] wdata_b;
  logic       gnt_b, rvalid_b;
  logic [7:0] rdata_b;
  logic       mem_ren, mem_wen;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [16];

  mem_port_arb #(.AW(4), .DW(8), .MAX_LOCK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_a     (req_a),
    .we_a      (we_a),
    .lock_a    (lock_a),
    .addr_a    (addr_a),
    .wdata_a   (wdata_a),
    .gnt_a     (gnt_a),
    .rvalid_a  (rvalid_a),
    .rdata_a   (rdata_a),
    .req_b     (req_b),
    .we_b      (we_b),
    .lock_b    (lock_b),
    .addr_b    (addr_b),
    .wdata_b   (wdata_b),
    .gnt_b     (gnt_b),
    .rvalid_b  (rvalid_b),
    .rdata_b   (rdata_b),
    .mem_ren   (mem_ren),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Reset contents of the register file: {~addr, addr}.
  function automatic logic [7:0] pat(input int a);
    logic [3:0] x;
    x = 4'(a);
    return {~x, x};
  endfunction

  // Register file model: write on mem_wen, read data valid one cycle after mem_ren.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= pat(i);
      mem_rdata <= 8'h00;
    end else begin
      if (mem_wen) mem[mem_addr] <= mem_wdata;
      if (mem_ren) mem_rdata <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req_a = 1'b0; we_a = 1'b0; lock_a = 1'b0; addr_a = 4'h0; wdata_a = 8'h00;
    req_b = 1'b0; we_b = 1'b0; lock_b = 1'b0; addr_b = 4'h0; wdata_b = 8'h00;
  endtask

  // Two reset edges; returns at a negedge with rst already released.
  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    logic exp_a;
    idle_inputs();
    rst = 1'b1;
    next_cycle();
    next_cycle();

    // ---- reset state (two reset edges seen, request held high) ----
    req_a = 1'b1; req_b = 1'b1;
    #1;
    check("rst_gnt_a", gnt_a, 0);
    check("rst_gnt_b", gnt_b, 0);
    check("rst_mem_ren", mem_ren, 0);
    check("rst_mem_wen", mem_wen, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_rvalid_a", rvalid_a, 0);
    check("rst_rvalid_b", rvalid_b, 0);
    check("rst_rdata_a", rdata_a, 0);
    check("rst_rdata_b", rdata_b, 0);
    next_cycle();
    rst = 1'b0;
    idle_inputs();

    // ---- a writes 0xA5 to addr 3, then reads addr 3 ----
    req_a = 1'b1; we_a = 1'b1; addr_a = 4'd3; wdata_a = 8'hA5;
    #1;
    check("wr_gnt_a", gnt_a, 1);
    check("wr_gnt_b", gnt_b, 0);
    next_cycle();
    we_a = 1'b0; wdata_a = 8'h00;
    #1;
    check("rd_gnt_a", gnt_a, 1);
    check("wr_mem_wen", mem_wen, 1);
    check("wr_mem_ren", mem_ren, 0);
    check("wr_mem_addr", mem_addr, 3);
    check("wr_mem_wdata", mem_wdata, 8'hA5);
    next_cycle();
    idle_inputs();
    #1;
    check("rd_mem_ren", mem_ren, 1);
    check("rd_mem_wen", mem_wen, 0);
    check("rd_mem_addr", mem_addr, 3);
    check("rd_rvalid_early", rvalid_a, 0);
    next_cycle();
    #1;
    check("bubble_mem_ren", mem_ren, 0);
    check("bubble_mem_wen", mem_wen, 0);
    check("bubble_mem_addr_hold", mem_addr, 3);
    check("bubble_rvalid_a", rvalid_a, 0);
    next_cycle();
    #1;
    check("rd_rvalid_a", rvalid_a, 1);
    check("rd_rdata_a", rdata_a, 8'hA5);
    check("rd_rvalid_b", rvalid_b, 0);
    next_cycle();
    #1;
    check("rd_rvalid_a_pulse", rvalid_a, 0);
    check("rd_rdata_a_hold", rdata_a, 8'hA5);

    // ---- both request reads for 6 cycles ----
    do_reset();
    for (int i = 0; i < 6; i++) begin
      req_a = 1'b1; addr_a = 4'(i);
      req_b = 1'b1; addr_b = 4'(i + 8);
      #1;
`ifdef MEM_ARB_FIXED_PRIO_EN
      exp_a = 1'b1;
`else
      exp_a = (i % 2 == 0);
`endif
      check("rr_gnt_a", gnt_a, 32'(exp_a));
      check("rr_gnt_b", gnt_b, 32'(!exp_a));
      if (i > 0) check("rr_mem_ren", mem_ren, 1);
      next_cycle();
    end
    idle_inputs();

    // ---- a locks for 8 cycles while b requests ----
    do_reset();
    for (int i = 0; i < 8; i++) begin
      req_a = 1'b1; lock_a = 1'b1; addr_a = 4'd1;
      req_b = 1'b1; lock_b = 1'b0; addr_b = 4'd2;
      #1;
`ifdef MEM_ARB_FIXED_PRIO_EN
      exp_a = 1'b1;
`else
      exp_a = (i != 4);
`endif
      check("lock_gnt_a", gnt_a, 32'(exp_a));
      check("lock_gnt_b", gnt_b, 32'(!exp_a));
      next_cycle();
    end
    idle_inputs();

    // ---- b writes 0x3C to addr 15, a reads addr 15 next cycle ----
    do_reset();
    req_b = 1'b1; we_b = 1'b1; addr_b = 4'd15; wdata_b = 8'h3C;
    #1;
    check("bw_gnt_b", gnt_b, 1);
    check("bw_gnt_a", gnt_a, 0);
    next_cycle();
    idle_inputs();
    req_a = 1'b1; addr_a = 4'd15;
    #1;
    check("ar_gnt_a", gnt_a, 1);
    check("ar_rvalid_b", rvalid_b, 0);
    next_cycle();
    idle_inputs();
    for (int j = 2; j < 6; j++) begin
      #1;
      check("raw_rvalid_b", rvalid_b, 0);
      check("raw_rvalid_a", rvalid_a, 32'(j == 4));
      if (j == 4) check("raw_rdata_a", rdata_a, 8'h3C);
      next_cycle();
    end
    #1;
    check("raw_rdata_a_hold", rdata_a, 8'h3C);

    // ---- a reads addr 0, reset hits the next cycle for 3 cycles ----
    req_a = 1'b1; addr_a = 4'd0;
    #1;
    check("rstmid_gnt_a", gnt_a, 1);
    next_cycle();
    rst = 1'b1;
    #1;
    check("rstmid_gnt_a_0", gnt_a, 0);
    check("rstmid_gnt_b_0", gnt_b, 0);
    next_cycle();
    for (int j = 0; j < 2; j++) begin
      req_b = 1'b1;
      #1;
      check("rstmid_gnt_a", gnt_a, 0);
      check("rstmid_gnt_b", gnt_b, 0);
      check("rstmid_mem_ren", mem_ren, 0);
      check("rstmid_mem_wen", mem_wen, 0);
      check("rstmid_mem_addr", mem_addr, 0);
      check("rstmid_mem_wdata", mem_wdata, 0);
      check("rstmid_rvalid_a", rvalid_a, 0);
      check("rstmid_rvalid_b", rvalid_b, 0);
      check("rstmid_rdata_a", rdata_a, 0);
      check("rstmid_rdata_b", rdata_b, 0);
      next_cycle();
    end
    rst = 1'b0;
    idle_inputs();
    for (int j = 0; j < 6; j++) begin
      #1;
      check("rstmid_no_rvalid_a", rvalid_a, 0);
      next_cycle();
    end

    // ---- alternating back-to-back reads over 16 addresses ----
    for (int j = 0; j < 20; j++) begin
      idle_inputs();
      if (j < 16) begin
        if (j % 2 == 0) begin
          req_a = 1'b1; addr_a = 4'(j);
        end else begin
          req_b = 1'b1; addr_b = 4'(j);
        end
      end
      #1;
      if (j < 16) begin
        check("b2b_gnt_a", gnt_a, 32'(j % 2 == 0));
        check("b2b_gnt_b", gnt_b, 32'(j % 2 == 1));
      end
      if (j >= 1 && j <= 16) begin
        check("b2b_mem_ren", mem_ren, 1);
        check("b2b_mem_addr", mem_addr, 32'(j - 1));
      end
      if (j >= 3 && j <= 18) begin
        check("b2b_rvalid_a", rvalid_a, 32'((j - 3) % 2 == 0));
        check("b2b_rvalid_b", rvalid_b, 32'((j - 3) % 2 == 1));
        if ((j - 3) % 2 == 0) check("b2b_rdata_a", rdata_a, 32'(pat(j - 3)));
        else                  check("b2b_rdata_b", rdata_b, 32'(pat(j - 3)));
      end
      if (j == 19) begin
        check("b2b_rvalid_a_end", rvalid_a, 0);
        check("b2b_rvalid_b_end", rvalid_b, 0);
      end
      next_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
